// File: rtl/readout_integrator.sv
// rtl/readout_integrator.sv - boxcar I/Q integrator with threshold state decision
// Optional: define READOUT_INTEGRATOR_SATURATE_EN for saturating accumulation
// (default build wraps modulo 2^ACC_WIDTH).
module readout_integrator #(
  parameter int INPUT_WIDTH = 16,
  parameter int ACC_WIDTH   = 32,
  parameter int LEN_WIDTH   = 12
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  input  logic [LEN_WIDTH-1:0]          int_len,
  input  logic                          in_valid,
  input  logic signed [INPUT_WIDTH-1:0] i_in,
  input  logic signed [INPUT_WIDTH-1:0] q_in,
  input  logic signed [ACC_WIDTH-1:0]   threshold,
  output logic                          busy,
  output logic                          out_valid,
  output logic signed [ACC_WIDTH-1:0]   i_acc,
  output logic signed [ACC_WIDTH-1:0]   q_acc,
  output logic                          state_out
);

  typedef enum logic [1:0] {IDLE, INTEG, DONE} state_t;

  state_t                       state;
  state_t                       state_next;
  logic signed [ACC_WIDTH-1:0]  sum_i;
  logic signed [ACC_WIDTH-1:0]  sum_q;
  logic signed [ACC_WIDTH-1:0]  next_i;
  logic signed [ACC_WIDTH-1:0]  next_q;
  logic signed [ACC_WIDTH-1:0]  thr_q;
  logic [LEN_WIDTH-1:0]         len_q;
  logic [LEN_WIDTH-1:0]         count;
  logic [LEN_WIDTH-1:0]         count_inc;
  logic                         accept;
  logic                         last;
  logic                         begin_win;

  // One accumulate step: sign-extend the sample and add, wrapping or clamping.
  function automatic logic signed [ACC_WIDTH-1:0] acc_add(
    input logic signed [ACC_WIDTH-1:0]   a,
    input logic signed [INPUT_WIDTH-1:0] b
  );
`ifdef READOUT_INTEGRATOR_SATURATE_EN
    logic signed [ACC_WIDTH:0] wide;
    wide = (ACC_WIDTH+1)'(a) + (ACC_WIDTH+1)'(b);
    // The top two bits disagree only when the true sum left the signed range.
    if (wide[ACC_WIDTH] != wide[ACC_WIDTH-1]) begin
      if (wide[ACC_WIDTH]) acc_add = {1'b1, {(ACC_WIDTH-1){1'b0}}};
      else                 acc_add = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end else begin
      acc_add = wide[ACC_WIDTH-1:0];
    end
`else
    acc_add = a + ACC_WIDTH'(b);
`endif
  endfunction

  assign next_i    = acc_add(sum_i, i_in);
  assign next_q    = acc_add(sum_q, q_in);
  assign count_inc = count + 1'b1;
  assign begin_win = (state == IDLE) && start && (int_len != '0);
  // Abort wins over both accumulation and completion.
  assign accept    = (state == INTEG) && in_valid && !abort;
  assign last      = accept && (count_inc == len_q);
  assign busy      = (state == INTEG);
  assign out_valid = (state == DONE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; start is only honoured from IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (begin_win) state_next = INTEG;
      INTEG: begin
        if (abort)     state_next = IDLE;
        else if (last) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Window datapath: latch config on start, accumulate, publish results on the last sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_i     <= '0;
      sum_q     <= '0;
      count     <= '0;
      len_q     <= '0;
      thr_q     <= '0;
      i_acc     <= '0;
      q_acc     <= '0;
      state_out <= 1'b0;
    end else begin
      if (begin_win) begin
        len_q <= int_len;
        thr_q <= threshold;
        sum_i <= '0;
        sum_q <= '0;
        count <= '0;
      end
      if (accept) begin
        sum_i <= next_i;
        sum_q <= next_q;
        count <= count_inc;
      end
      if (last) begin
        i_acc     <= next_i;
        q_acc     <= next_q;
        state_out <= (next_i >= thr_q);
      end
    end
  end

endmodule

// File: tb/tb_readout_integrator.sv
// tb/tb_readout_integrator.sv - directed self-checking bench for readout_integrator
module tb_readout_integrator;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               abort;
  logic [11:0]        int_len;
  logic               in_valid;
  logic signed [15:0] i_in;
  logic signed [15:0] q_in;
  logic signed [31:0] threshold;
  logic signed [15:0] threshold16;
  logic               busy, out_valid, state_out;
  logic signed [31:0] i_acc, q_acc;
  logic               busy16, out_valid16, state_out16;
  logic signed [15:0] i_acc16, q_acc16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  readout_integrator dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .int_len(int_len),
    .in_valid(in_valid), .i_in(i_in), .q_in(q_in), .threshold(threshold),
    .busy(busy), .out_valid(out_valid), .i_acc(i_acc), .q_acc(q_acc),
    .state_out(state_out)
  );

  readout_integrator #(.INPUT_WIDTH(16), .ACC_WIDTH(16), .LEN_WIDTH(12)) dut16 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .int_len(int_len),
    .in_valid(in_valid), .i_in(i_in), .q_in(q_in), .threshold(threshold16),
    .busy(busy16), .out_valid(out_valid16), .i_acc(i_acc16), .q_acc(q_acc16),
    .state_out(state_out16)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic v, input logic signed [15:0] i, input logic signed [15:0] q);
    in_valid = v; i_in = i; q_in = q;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic begin_window(input logic [11:0] len, input logic signed [31:0] thr);
    start = 1'b1; int_len = len; threshold = thr;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; int_len = '0; in_valid = 1'b0;
    i_in = '0; q_in = '0; threshold = '0; threshold16 = '0;
    tick(); tick();
    chk("reset_busy", busy, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_i_acc", i_acc, 0);
    chk("reset_state_out", state_out, 0);
    rst = 1'b0;
    tick();

    // Constant input, sample coincident with start is ignored.
    start = 1'b1; int_len = 12'd8; threshold = 0;
    in_valid = 1'b1; i_in = 16'sd100; q_in = -16'sd3;
    tick();
    start = 1'b0;
    chk("const_busy", busy, 1);
    for (int k = 0; k < 7; k++) sample(1'b1, 16'sd100, -16'sd3);
    chk("const_no_early_valid", out_valid, 0);
    start = 1'b1; int_len = 12'd2;
    sample(1'b1, 16'sd100, -16'sd3);
    chk("const_out_valid", out_valid, 1);
    chk("const_busy_done", busy, 0);
    chk("const_i_acc", i_acc, 800);
    chk("const_q_acc", q_acc, -24);
    chk("const_state", state_out, 1);
    tick();
    start = 1'b0;
    chk("const_pulse_end", out_valid, 0);
    chk("start_in_done_ignored", busy, 0);

    // Reset mid-window clears outputs asynchronously.
    begin_window(12'd10, 0);
    for (int k = 0; k < 5; k++) sample(1'b1, 16'sd9, 16'sd9);
    rst = 1'b1;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_i_acc", i_acc, 0);
    chk("rst_mid_q_acc", q_acc, 0);
    chk("rst_mid_state", state_out, 0);
    rst = 1'b0;
    tick();
    begin_window(12'd4, 0);
    for (int k = 0; k < 4; k++) sample(1'b1, 16'sd7, 16'sd1);
    chk("after_rst_valid", out_valid, 1);
    chk("after_rst_i_acc", i_acc, 28);
    chk("after_rst_q_acc", q_acc, 4);
    tick();

    // Gapped valid, threshold just above and exactly at the sum.
    for (int t = 0; t < 2; t++) begin
      logic [6:0] pat;
      pat = 7'b1011001;
      begin_window(12'd4, (t == 0) ? -32'sd199 : -32'sd200);
      for (int k = 0; k < 7; k++) begin
        if (k == 6) chk("gap_not_done_early", out_valid, 0);
        sample(pat[k], -16'sd50, 16'sd0);
      end
      chk("gap_out_valid", out_valid, 1);
      chk("gap_i_acc", i_acc, -200);
      chk("gap_state", state_out, (t == 0) ? 0 : 1);
      tick();
    end

    // Zero-length start is ignored.
    begin_window(12'd0, 0);
    chk("zero_len_busy", busy, 0);
    tick();
    chk("zero_len_out_valid", out_valid, 0);

    // Start during INTEG does not restart or shorten the window.
    begin_window(12'd3, 0);
    sample(1'b1, 16'sd1, 16'sd0);
    start = 1'b1; int_len = 12'd1;
    sample(1'b1, 16'sd2, 16'sd0);
    start = 1'b0;
    chk("restart_ignored_busy", busy, 1);
    chk("restart_ignored_no_valid", out_valid, 0);
    sample(1'b1, 16'sd4, 16'sd5);
    chk("restart_ignored_valid", out_valid, 1);
    chk("restart_ignored_i_acc", i_acc, 7);
    tick();

    // Abort mid-window keeps the previous results.
    begin_window(12'd10, 32'sd1000);
    for (int k = 0; k < 6; k++) sample(1'b1, -16'sd100, 16'sd3);
    abort = 1'b1;
    sample(1'b1, -16'sd100, 16'sd3);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_no_valid", out_valid, 0);
    tick();
    chk("abort_no_valid_late", out_valid, 0);
    chk("abort_keep_i", i_acc, 7);
    chk("abort_keep_q", q_acc, 5);
    chk("abort_keep_state", state_out, 1);

    // Abort on the completing sample wins.
    begin_window(12'd2, 0);
    sample(1'b1, 16'sd50, 16'sd0);
    abort = 1'b1;
    sample(1'b1, 16'sd50, 16'sd0);
    abort = 1'b0;
    chk("abort_prio_no_valid", out_valid, 0);
    chk("abort_prio_keep_i", i_acc, 7);
    tick();

    // Overflow: 3 x 20000 into a 16-bit accumulator.
    begin_window(12'd3, 0);
    for (int k = 0; k < 3; k++) sample(1'b1, 16'sd20000, 16'sd0);
    chk("ovf_valid16", out_valid16, 1);
    chk("ovf_wide_i_acc", i_acc, 60000);
`ifdef READOUT_INTEGRATOR_SATURATE_EN
    chk("ovf_i_acc16", i_acc16, 32767);
    chk("ovf_state16", state_out16, 1);
`else
    chk("ovf_i_acc16", i_acc16, -5536);
    chk("ovf_state16", state_out16, 0);
`endif
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
